axi4_rd_responder: RTL and testbench
====================================

AXI4_RD_RESPONDER -- requirements
Module: axi4_rd_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit memory words; fixed to a power of two between 16 and 1024.
REQ-002 SHALL have parameter AQ_DEPTH, default 2: number of entries in the read-address queue.
REQ-003 s_axi_aclk  in  1  single clock; all logic rises on its positive edge.
REQ-004 s_axi_aresetn  in  1  reset; asynchronous assert, active-low.
REQ-005 s_axi_arid  in  3  read transaction ID.
REQ-006 s_axi_araddr  in  32  read start byte address.
REQ-007 s_axi_arlen  in  8  beats minus 1.
REQ-008 s_axi_arsize  in  3  bytes per beat; only 3'b010 (4 bytes) is legal.
REQ-009 s_axi_arburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-010 s_axi_arvalid / s_axi_arready  in / out  1 each  AR handshake.
REQ-011 s_axi_rid  out  3  ID of the burst being returned.
REQ-012 s_axi_rdata  out  32  read beat data.
REQ-013 s_axi_rresp  out  2  beat response: 00 OKAY, 10 SLVERR.
REQ-014 s_axi_rlast  out  1  final beat of the burst.
REQ-015 s_axi_rvalid / s_axi_rready  out / in  1 each  R handshake.
REQ-016 ld_en, ld_addr[$clog2(DEPTH_WORDS)-1:0], ld_data[31:0]  in  memory preload port; word-addressed.

Function
REQ-017 SHALL accept an AR transfer on any edge where arvalid && arready, and push {id, addr, len, size, burst} into the AR queue; arready = queue not full.
REQ-018 SHALL run a burst engine with two states: IDLE (queue empty or no burst loaded) and BURST (returning beats); IDLE -> BURST on the edge that pops a non-empty queue.
REQ-019 SHALL have latency from the AR handshake edge N to the first rvalid: rvalid is high after edge N+1.
REQ-020 SHALL hold rvalid, rdata, rresp, rid and rlast stable while rvalid && !rready.
REQ-021 On the beat handshake with rlast, SHALL pop the next queued burst on the same edge with no idle cycle if the queue is non-empty; otherwise SHALL return to IDLE.
REQ-022 SHALL set rlast only when the beat count equals arlen.
REQ-023 Address update per beat: FIXED holds the address; INCR adds 4; WRAP keeps the address bits above mask=(arlen+1)*4-1 and advances the bits within mask by 4 modulo the mask.
REQ-024 SHALL treat arburst=11, arsize!=010, or WRAP with arlen not in {1,3,7,15} as INCR stepping, with SLVERR and rdata=0 on every beat.
REQ-025 SHALL return SLVERR and rdata=0 for any beat whose byte address is >= DEPTH_WORDS*4, and OKAY with mem[addr[..:2]] otherwise; the decision is made per beat.
REQ-026 SHALL write ld_data into mem[ld_addr] on the edge where ld_en=1; any beat presented after that edge returns the new value.
REQ-027 SHALL ignore araddr[1:0] (beats are word-aligned) and SHALL accept an AR push and a queue pop on the same edge while the queue is full.

Reset
REQ-028 While aresetn=0: arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, AR queue flushed, engine in IDLE; memory contents are not reset.
REQ-029 Reset during a burst SHALL abandon the burst with no further beats; arready=1 on the first edge after release.

Verification
REQ-030 Preload mem[i]=0x100+i; INCR addr 0x0 len 3 id 5, rready=1 -> rdata 0x100..0x103, OKAY, rid 5, rlast on beat 4 only, first rvalid 2 edges after AR.
REQ-031 WRAP addr 0x38 len 3 -> rdata 0x10E, 0x10F, 0x10C, 0x10D; FIXED addr 0x8 len 2 -> 0x102 three times.
REQ-032 INCR addr 0x3F8 len 3 (DEPTH 256) -> 0x1FE, 0x1FF OKAY, then two SLVERR beats with rdata 0; arsize=3'b001 -> all beats SLVERR.
REQ-033 Three back-to-back ARs with rready toggling 1/0 -> arready low while the queue is full, outputs stable during stalls, and no bubble between bursts.
REQ-034 Assert aresetn mid-burst -> rvalid=0 immediately; after release, arready=1 and a new burst returns correct data.

Source files
------------

// File: rtl/axi4_rd_responder.sv
// AXI4 read-only slave over a preloadable word memory: queued AR channel feeding a
// burst engine that returns FIXED/INCR/WRAP beats with per-beat range checking.
module axi4_rd_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AQ_DEPTH    = 2
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [2:0]                     s_axi_arid,
    input  logic [31:0]                    s_axi_araddr,
    input  logic [7:0]                     s_axi_arlen,
    input  logic [2:0]                     s_axi_arsize,
    input  logic [1:0]                     s_axi_arburst,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [2:0]                     s_axi_rid,
    output logic [31:0]                    s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rlast,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = (AQ_DEPTH > 1) ? $clog2(AQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(AQ_DEPTH + 1);

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef enum logic [0:0] {StIdle, StBurst} state_t;

    logic [31:0] mem [DEPTH_WORDS];
    ar_t         aq  [AQ_DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ar_en_q;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q, cnt_q;
    logic [1:0]  mode_q;
    logic        err_q;
    logic        rvalid_q, rlast_q;
    logic [2:0]  rid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    ar_t         head;
    logic        head_err, push, pop, beat_xfer, advance;
    logic [31:0] beat_addr, mem_word;
    logic        beat_err, beat_last;

    // Next beat address; error bursts are forced to INCR mode before reaching here.
    function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [1:0] mode,
                                              input logic [7:0] len);
        logic [31:0] mask;
        mask = ({24'd0, len} + 32'd1) * 32'd4 - 32'd1;
        case (mode)
            2'b00:   step_addr = a;
            2'b10:   step_addr = (a & ~mask) | ((a + 32'd4) & mask);
            default: step_addr = a + 32'd4;
        endcase
    endfunction

    always_comb begin
        head      = aq[rd_ptr_q];
        head_err  = (head.burst == 2'b11) || (head.size != 3'b010) ||
                    ((head.burst == 2'b10) && !(head.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        beat_xfer = rvalid_q && s_axi_rready;
        pop       = (count_q != '0) && ((state_q == StIdle) || (beat_xfer && rlast_q));
        advance   = beat_xfer && !rlast_q;
        // While full, a same-edge pop frees the slot being written.
        s_axi_arready = ar_en_q && ((count_q != CW'(AQ_DEPTH)) || pop);
        push      = s_axi_arvalid && s_axi_arready;
        if (pop) begin
            beat_addr = {head.addr[31:2], 2'b00};
            beat_err  = head_err;
            beat_last = (head.len == 8'd0);
        end else begin
            beat_addr = step_addr(addr_q, mode_q, len_q);
            beat_err  = err_q;
            beat_last = ((cnt_q + 8'd1) == len_q);
        end
        beat_err = beat_err || (|beat_addr[31:AW+2]);
        mem_word = (ld_en && (ld_addr == beat_addr[AW+1:2])) ? ld_data : mem[beat_addr[AW+1:2]];
    end

    always_ff @(posedge s_axi_aclk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (push) aq[wr_ptr_q] <= '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen,
                                    size: s_axi_arsize, burst: s_axi_arburst};
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ar_en_q  <= 1'b0;
        end else begin
            ar_en_q <= 1'b1;
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(AQ_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(AQ_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else begin
            case (state_q)
                StIdle:  if (pop) state_q <= StBurst;
                StBurst: if (beat_xfer && rlast_q && !pop) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (pop || advance) begin
                rvalid_q <= 1'b1;
                rdata_q  <= beat_err ? 32'd0 : mem_word;
                rresp_q  <= beat_err ? 2'b10 : 2'b00;
                rlast_q  <= beat_last;
                addr_q   <= beat_addr;
            end else if (beat_xfer) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
            if (pop) begin
                rid_q  <= head.id;
                len_q  <= head.len;
                mode_q <= head_err ? 2'b01 : head.burst;
                err_q  <= head_err;
                cnt_q  <= '0;
            end else if (advance) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rlast  = rlast_q;
    assign s_axi_rid    = rid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;

endmodule

// File: tb/tb_axi4_rd_responder.sv
// Randomised scoreboard bench for axi4_rd_responder: expected beats come from an
// arithmetic burst-address model over a shadow copy of the memory.
module tb_axi4_rd_responder;
    localparam int unsigned DEPTH_WORDS = 256;
    localparam int unsigned AQ_DEPTH    = 2;
    localparam int unsigned AW          = $clog2(DEPTH_WORDS);

    logic          clk = 1'b0;
    logic          aresetn;
    logic [2:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready;
    logic [2:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic [31:0] mem_model [DEPTH_WORDS];
    beat_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rr_mode  = 0;

    axi4_rd_responder #(.DEPTH_WORDS(DEPTH_WORDS), .AQ_DEPTH(AQ_DEPTH)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    initial forever #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: beat i address from the start address by plain arithmetic.
    function automatic void push_expected(input logic [2:0] id, input logic [31:0] addr,
                                          input logic [7:0] len, input logic [2:0] size,
                                          input logic [1:0] burst);
        logic        err;
        logic [31:0] a0, a, wsize, base;
        beat_t       b;
        err = (burst == 2'd3) || (size != 3'd2) ||
              (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        a0 = addr & 32'hFFFF_FFFC;
        for (int i = 0; i <= int'(len); i++) begin
            if (err || burst == 2'd1) begin
                a = a0 + 32'(4 * i);
            end else if (burst == 2'd0) begin
                a = a0;
            end else begin
                wsize = (32'(len) + 1) * 4;
                base  = (a0 / wsize) * wsize;
                a     = base + ((a0 - base + 32'(4 * i)) % wsize);
            end
            b.id   = id;
            b.last = (i == int'(len));
            if (err || a >= DEPTH_WORDS * 4) begin
                b.data = 32'd0;
                b.resp = 2'b10;
            end else begin
                b.data = mem_model[a / 4];
                b.resp = 2'b00;
            end
            sb.push_back(b);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       rready = 1'b1;
            1:       rready = 1'($urandom_range(0, 1));
            2:       rready = ~rready;
            default: rready = 1'b0;
        endcase
    end

    // Monitor: compares every handshaked beat, stall stability, and back-to-back bursts.
    initial begin
        logic [38:0] saved;
        bit          stalled, expect_cont;
        beat_t       exp_b;
        stalled     = 0;
        expect_cont = 0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                stalled     = 0;
                expect_cont = 0;
            end else begin
                if (expect_cont) begin
                    check("no_bubble_rvalid", 64'(rvalid), 64'd1);
                    expect_cont = 0;
                end
                if (stalled) begin
                    check("stall_hold", 64'({rvalid, rid, rdata, rresp, rlast}), 64'(saved));
                    stalled = 0;
                end
                if (rvalid && rready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 64'({rid, rdata, rresp, rlast}), 64'd0);
                        n_fail += (n_fail == 0 && {rid, rdata, rresp, rlast} == '0) ? 1 : 0;
                    end else begin
                        exp_b = sb.pop_front();
                        check("beat", 64'({rid, rdata, rresp, rlast}), 64'(exp_b));
                        if (rlast && sb.size() > 0) expect_cont = 1;
                    end
                end else if (rvalid) begin
                    stalled = 1;
                    saved   = {rvalid, rid, rdata, rresp, rlast};
                end
            end
        end
    end

    task automatic send_ar(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit lat);
        bit ok, rdy;
        ok      = 0;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            rdy = arready;
            @(posedge clk);
            if (rdy) ok = 1;
        end
        #1;
        arvalid = 1'b0;
        if (!ok) begin
            check("ar_timeout", 64'd0, 64'd1);
        end else begin
            push_expected(id, addr, len, size, burst);
            if (lat) begin
                check("latency_edge_n", 64'(rvalid), 64'd0);
                @(posedge clk);
                #1;
                check("latency_edge_n1", 64'(rvalid), 64'd1);
            end
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("drain_idle_rvalid", 64'(rvalid), 64'd0);
    endtask

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            ld_en   = 1'b1;
            ld_addr = AW'(i);
            ld_data = rnd ? $urandom : 32'h100 + 32'(i);
            mem_model[i] = ld_data;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
    endtask

    initial begin
        logic [1:0]  b;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [31:0] a;
        aresetn = 1'b0;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        rready  = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_outputs", 64'({rlast, rresp, rid, rdata}), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_arready", 64'(arready), 64'd1);
        load_mem(0);

        // Directed bursts over mem[i] = 0x100 + i.
        send_ar(3'd5, 32'h0, 8'd3, 3'd2, 2'd1, 1);
        send_ar(3'd1, 32'h38, 8'd3, 3'd2, 2'd2, 0);
        send_ar(3'd2, 32'h8, 8'd2, 3'd2, 2'd0, 0);
        send_ar(3'd3, 32'h3F8, 8'd3, 3'd2, 2'd1, 0);
        send_ar(3'd4, 32'h0, 8'd3, 3'd1, 2'd1, 0);
        send_ar(3'd6, 32'h13, 8'd0, 3'd2, 2'd1, 0);
        drain();

        // Fill the queue behind a stalled burst, then release with toggling rready.
        rr_mode = 3;
        @(posedge clk);
        #1;
        send_ar(3'd1, 32'h10, 8'd3, 3'd2, 2'd1, 0);
        send_ar(3'd2, 32'h20, 8'd3, 3'd2, 2'd2, 0);
        send_ar(3'd3, 32'h30, 8'd1, 3'd2, 2'd0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("full_arready_low", 64'(arready), 64'd0);
        end
        @(posedge clk);
        #1;
        rr_mode = 2;
        send_ar(3'd7, 32'h44, 8'd2, 3'd2, 2'd1, 0);
        drain();

        // Random traffic against a randomised memory image.
        rr_mode = 0;
        load_mem(1);
        for (int t = 0; t < 160; t++) begin
            if (t % 20 == 0) rr_mode = $urandom_range(0, 2);
            b = 2'($urandom_range(0, 3));
            l = (b == 2'd2 && $urandom_range(0, 3) != 0) ? 8'((4 << $urandom_range(0, 2)) - 1)
                                                          : 8'($urandom_range(0, 15));
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            case ($urandom_range(0, 7))
                0:       a = 32'h3C0 + 32'($urandom_range(0, 127));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 1023));
            endcase
            send_ar(3'($urandom_range(0, 7)), a, l, s, b, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rr_mode = 0;
        drain();

        // Reset in the middle of a stalled burst.
        rr_mode = 3;
        @(posedge clk);
        #1;
        send_ar(3'd3, 32'h40, 8'd7, 3'd2, 2'd1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_rvalid", 64'(rvalid), 64'd1);
        aresetn = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_arready", 64'(arready), 64'd0);
        check("mid_rst_outputs", 64'({rlast, rresp, rid, rdata}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        check("rel_arready_before_edge", 64'(arready), 64'd0);
        @(posedge clk);
        #1;
        check("rel_arready_after_edge", 64'(arready), 64'd1);
        rr_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abandoned_no_beats", 64'(rvalid), 64'd0);
        end
        @(posedge clk);
        #1;
        send_ar(3'd2, 32'h10, 8'd3, 3'd2, 2'd1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
